// File: rtl/multdiv_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_issue_ctrl_pkg
//   Shared types and constants for the mult/div issue controller:
//     - state_e : controller state encoding (IDLE/START/BUSY/DONE)
//     - op_e    : operation selector held for the duration of an op
//     - default exception register number and exception codes
//     - counter widths for the blanking and timeout counters
//     - exc_code() : picks the rstatus value for a given op
// -----------------------------------------------------------------------------
package multdiv_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  localparam int RSTATUS_REG_NUM   = 30;
  localparam int MULT_EXC_CODE_DEF = 4;
  localparam int DIV_EXC_CODE_DEF  = 5;

  // Blanking counter holds BLANK_CYCLES (expected < 16); timeout counter is
  // 6 bits, so TIMEOUT_CYCLES must stay within 1..64.
  localparam int BLANK_W   = 4;
  localparam int TIMEOUT_W = 6;

  // rstatus value written when the op ends in an exception (zero-extended).
  function automatic logic [31:0] exc_code(input op_e op,
                                           input int  mult_code,
                                           input int  div_code);
    return (op == OP_DIV) ? 32'(div_code) : 32'(mult_code);
  endfunction

endpackage

// File: rtl/md_wb_capture.sv
// -----------------------------------------------------------------------------
// md_wb_capture
//   Captures the multdiv outcome into the writeback registers. On capture,
//   an exception redirects the write to the rstatus register with the op's
//   exception code; otherwise the result goes to the instruction's rd.
//   Also records whether the writeback is a real register write ($r0 is
//   never written, but exceptions always are).
//   Ports:
//     clock, reset : rising-edge clock, synchronous active-high clear
//     capture      : load the writeback registers this cycle
//     exception    : outcome is an exception (multdiv or timeout)
//     op           : operation in flight (selects the exception code)
//     rd           : destination of the instruction
//     result       : multdiv data result
//     wb_rd        : captured writeback register
//     wb_data      : captured writeback value
//     wb_write     : captured "this writeback modifies a register" flag
// -----------------------------------------------------------------------------
module md_wb_capture
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int RSTATUS_REG   = RSTATUS_REG_NUM,
  parameter int MULT_EXC_CODE = MULT_EXC_CODE_DEF,
  parameter int DIV_EXC_CODE  = DIV_EXC_CODE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture,
  input  logic        exception,
  input  op_e         op,
  input  logic [4:0]  rd,
  input  logic [31:0] result,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_write
);

  logic [4:0]  rd_d;
  logic [31:0] data_d;
  logic        write_d;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    rd_d    = rd;
    data_d  = result;
    write_d = (rd != 5'd0);
    if (exception) begin
      rd_d    = 5'(RSTATUS_REG);
      data_d  = exc_code(op, MULT_EXC_CODE, DIV_EXC_CODE);
      write_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_write <= 1'b0;
    end else if (capture) begin
      wb_rd    <= rd_d;
      wb_data  <= data_d;
      wb_write <= write_d;
    end
  end

endmodule

// File: rtl/register32.sv
// -----------------------------------------------------------------------------
// register32
//   32-bit enabled register with synchronous active-high clear.
//   Ports:
//     clock : rising-edge clock
//     reset : synchronous, active-high; clears q
//     en    : load d into q on the next rising edge
//     d     : data in
//     q     : registered data out
// -----------------------------------------------------------------------------
module register32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_issue_ctrl
//   Sits between the execute stage and the multdiv unit. A mult/div in
//   execute is turned into a single ctrl_MULT/ctrl_DIV pulse, its operands
//   are held stable (multdiv re-latches operands every clock), the pipeline
//   is stalled until multdiv reports ready, and a one-cycle writeback of the
//   result (or of the exception code to $rstatus) is issued.
//
//   State flow: IDLE -> START (ctrl pulse) -> BUSY (wait RDY) -> DONE (wb).
//   md_resultRDY is ignored for BLANK_CYCLES BUSY cycles after START so a
//   ready left over from a previous operation is not mistaken for this one.
//
//   Optional build macro MULTDIV_TIMEOUT_EN: adds a BUSY-cycle counter; after
//   TIMEOUT_CYCLES BUSY cycles without an accepted ready the op completes as
//   an exception. Without the macro BUSY waits indefinitely.
//
//   Ports:
//     clock, reset        : rising-edge clock, synchronous active-high reset
//     ex_is_mult/div      : execute stage holds a mult / div (mult wins)
//     ex_rd, ex_opA/B     : destination and operands from execute
//     flush               : squash any in-flight op
//     md_result           : multdiv data result
//     md_exception        : multdiv exception flag
//     md_resultRDY        : multdiv result ready
//     ctrl_MULT/DIV       : one-cycle start pulses to multdiv
//     md_operandA/B       : held operands to multdiv
//     stall               : freeze fetch/decode/execute
//     busy                : operation in flight (START or BUSY)
//     wb_valid            : one-cycle writeback strobe
//     wb_rd, wb_data      : writeback register and value
// -----------------------------------------------------------------------------
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int RSTATUS_REG   = RSTATUS_REG_NUM,
  parameter int MULT_EXC_CODE = MULT_EXC_CODE_DEF,
  parameter int DIV_EXC_CODE  = DIV_EXC_CODE_DEF,
  parameter int BLANK_CYCLES  = 2
`ifdef MULTDIV_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 40
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_is_mult,
  input  logic        ex_is_div,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_opA,
  input  logic [31:0] ex_opB,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  state_e             state;
  op_e                op_reg;
  logic [4:0]         rd_reg;
  logic [BLANK_W-1:0] blank_cnt;

  logic req;
  op_e  req_op;
  logic accept;
  logic timeout_hit;
  logic capture;
  logic capture_exc;
  logic wb_write;

  // A squashed instruction never starts an op; mult has priority over div.
  assign req    = (ex_is_mult | ex_is_div) & ~flush;
  assign req_op = ex_is_mult ? OP_MULT : OP_DIV;

  // Hold the requester in execute from its first cycle until DONE, where
  // stall drops so execute advances exactly once.
  assign stall = ((state == IDLE) & req) | (state == START) | (state == BUSY);
  assign busy  = (state == START) | (state == BUSY);

  // Start pulses decode registered state/op; a flush in START suppresses them.
  assign ctrl_MULT = (state == START) & ~flush & (op_reg == OP_MULT);
  assign ctrl_DIV  = (state == START) & ~flush & (op_reg == OP_DIV);

  assign wb_valid = (state == DONE) & wb_write;

  assign accept = (state == BUSY) & ~flush & (blank_cnt == '0) & md_resultRDY;

`ifdef MULTDIV_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;

  // An accepted ready in the same cycle takes precedence over the timeout.
  assign timeout_hit = (state == BUSY) & ~flush & ~accept
                     & (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign capture     = accept | timeout_hit;
  assign capture_exc = md_exception | timeout_hit;

  // Operands load only when a request is accepted, so they stay constant
  // from START through DONE and keep their last values after a flush.
  register32 u_opa (
    .clock (clock),
    .reset (reset),
    .en    ((state == IDLE) & req),
    .d     (ex_opA),
    .q     (md_operandA)
  );

  register32 u_opb (
    .clock (clock),
    .reset (reset),
    .en    ((state == IDLE) & req),
    .d     (ex_opB),
    .q     (md_operandB)
  );

  md_wb_capture #(
    .RSTATUS_REG   (RSTATUS_REG),
    .MULT_EXC_CODE (MULT_EXC_CODE),
    .DIV_EXC_CODE  (DIV_EXC_CODE)
  ) u_wb_capture (
    .clock     (clock),
    .reset     (reset),
    .capture   (capture),
    .exception (capture_exc),
    .op        (op_reg),
    .rd        (rd_reg),
    .result    (md_result),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_write  (wb_write)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op_reg    <= OP_MULT;
      rd_reg    <= '0;
      blank_cnt <= '0;
`ifdef MULTDIV_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_reg <= req_op;
            rd_reg <= ex_rd;
            state  <= START;
          end
        end

        START: begin
`ifdef MULTDIV_TIMEOUT_EN
          to_cnt <= '0;
`endif
          if (flush) begin
            state <= IDLE;
          end else begin
            blank_cnt <= BLANK_W'(BLANK_CYCLES);
            state     <= BUSY;
          end
        end

        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (blank_cnt != '0) begin
              blank_cnt <= blank_cnt - BLANK_W'(1);
            end
            if (capture) begin
              state <= DONE;
            end
`ifdef MULTDIV_TIMEOUT_EN
            else begin
              to_cnt <= to_cnt + TIMEOUT_W'(1);
            end
`endif
          end
        end

        DONE: begin
          // A request seen here waits in execute for the next IDLE cycle.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_issue_ctrl
//   Self-checking bench for multdiv_issue_ctrl. A small multdiv model answers
//   each ctrl pulse after a programmable latency; expected writebacks are
//   queued when an instruction is presented and popped when it completes.
// -----------------------------------------------------------------------------
module tb_multdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_is_mult, ex_is_div;
  logic [4:0]  ex_rd;
  logic [31:0] ex_opA, ex_opB;
  logic        flush;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_resultRDY;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] md_operandA, md_operandB;
  logic        stall, busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  // multdiv model state
  int                 model_lat = 16;
  int                 model_cnt = 0;
  logic               model_rdy = 1'b0;
  logic               stale_rdy = 1'b0;
  logic signed [63:0] prod;

  assign md_resultRDY = model_rdy | stale_rdy;

  always #5 clock = ~clock;

  multdiv_issue_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .ex_is_mult   (ex_is_mult),
    .ex_is_div    (ex_is_div),
    .ex_rd        (ex_rd),
    .ex_opA       (ex_opA),
    .ex_opB       (ex_opB),
    .flush        (flush),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_resultRDY (md_resultRDY),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .stall        (stall),
    .busy         (busy),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  // multdiv model: latches operands on a ctrl pulse, presents the result at
  // once and raises ready for one cycle model_lat cycles later (never if 0).
  always @(negedge clock) begin
    model_rdy = 1'b0;
    if (reset || flush) begin
      model_cnt = 0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      if (ctrl_MULT) begin
        prod         = $signed(md_operandA) * $signed(md_operandB);
        md_result    = prod[31:0];
        md_exception = (prod != {{32{prod[31]}}, prod[31:0]});
      end else begin
        md_exception = (md_operandB == 32'd0);
        md_result    = md_exception ? 32'd0 : $signed(md_operandA) / $signed(md_operandB);
      end
      model_cnt = model_lat;
    end else if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) model_rdy = 1'b1;
    end
  end

  // Presents one instruction (called #1 after a rising edge, DUT idle),
  // holds it until stall drops, then checks the completion cycle.
  task automatic run_op(input string name, input bit m, input bit d,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input bit ev, input logic [4:0] erd, input logic [31:0] edata,
                        input int elat);
    exp_t e;
    int   n_m = 0;
    int   n_d = 0;
    int   start_c = -1;
    int   done_c = -1;
    bit   ops_ok = 1'b1;
    e.valid = ev; e.rd = erd; e.data = edata;
    sb.push_back(e);
    ex_is_mult = m; ex_is_div = d; ex_opA = a; ex_opB = b; ex_rd = rd;
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      @(negedge clock);
      if (c == 0) begin
        n_vec++;
        if (stall !== 1'b1) begin
          n_err++; $display("FAIL %s req_stall: got %b want 1", name, stall);
        end
      end
      if (ctrl_MULT === 1'b1) n_m++;
      if (ctrl_DIV === 1'b1) n_d++;
      if (start_c < 0 && (ctrl_MULT === 1'b1 || ctrl_DIV === 1'b1)) start_c = c;
      if (start_c >= 0 && (md_operandA !== a || md_operandB !== b)) ops_ok = 1'b0;
      if (c > 0 && stall === 1'b0) done_c = c;
    end
    n_vec++;
    if (done_c < 0) begin
      n_err++; $display("FAIL %s done_timeout: stall never dropped within 200 cycles", name);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (wb_valid !== e.valid) begin
        n_err++; $display("FAIL %s wb_valid: got %b want %b", name, wb_valid, e.valid);
      end
      if (e.valid) begin
        n_vec++;
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          n_err++; $display("FAIL %s wb: got rd=%0d data=%h want rd=%0d data=%h",
                            name, wb_rd, wb_data, e.rd, e.data);
        end
      end
      n_vec++;
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL %s busy_in_done: got %b want 0", name, busy);
      end
      n_vec++;
      if (done_c - start_c !== elat) begin
        n_err++; $display("FAIL %s latency: got %0d want %0d cycles ctrl->done", name, done_c - start_c, elat);
      end
    end
    n_vec++;
    if (n_m !== int'(m) || n_d !== int'(!m && d)) begin
      n_err++; $display("FAIL %s ctrl_pulses: got mult=%0d div=%0d want mult=%0d div=%0d",
                        name, n_m, n_d, int'(m), int'(!m && d));
    end
    n_vec++;
    if (!ops_ok) begin
      n_err++; $display("FAIL %s operand_hold: operands changed while op in flight (want %h %h)", name, a, b);
    end
    @(posedge clock); #1;
    ex_is_mult = 1'b0; ex_is_div = 1'b0;
    @(negedge clock);
    n_vec++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s after_done: got wb_valid=%b busy=%b want 0 0", name, wb_valid, busy);
    end
    @(posedge clock); #1;
  endtask

  // Waits (bounded) for the ctrl pulse of a manually presented op.
  task automatic wait_ctrl(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (ctrl_MULT === 1'b1 || ctrl_DIV === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++; $display("FAIL %s ctrl_seen: no ctrl pulse within 10 cycles", name);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_vec++;
    if ({ctrl_MULT, ctrl_DIV, busy, stall, wb_valid, wb_rd, wb_data, md_operandA, md_operandB} !== '0) begin
      n_err++;
      $display("FAIL %s outputs: got cm=%b cd=%b busy=%b stall=%b wbv=%b rd=%0d data=%h a=%h b=%h want all 0",
               name, ctrl_MULT, ctrl_DIV, busy, stall, wb_valid, wb_rd, wb_data, md_operandA, md_operandB);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset_release");
    @(posedge clock); #1;
  endtask

  task automatic test_mult();
    run_op("mult_7x6", 1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 1'b1, 5'd3, 32'd42, 17);
  endtask

  task automatic test_div();
    run_op("div_by_zero", 1'b0, 1'b1, 32'd10, 32'd0, 5'd5, 1'b1, 5'd30, 32'd5, 17);
    run_op("div_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 5'd9, 1'b1, 5'd9, 32'd14, 17);
  endtask

  task automatic test_mult_overflow();
    run_op("mult_ovf", 1'b1, 1'b0, 32'h7FFFFFFF, 32'd2, 5'd12, 1'b1, 5'd30, 32'd4, 17);
  endtask

  task automatic test_mult_wins();
    run_op("mult_wins", 1'b1, 1'b1, 32'hFFFFFFFD, 32'd5, 5'd6, 1'b1, 5'd6, 32'hFFFFFFF1, 17);
  endtask

  task automatic test_stale_rdy();
    stale_rdy = 1'b1;
    run_op("stale_rdy", 1'b1, 1'b0, 32'd6, 32'd7, 5'd4, 1'b1, 5'd4, 32'd42, 4);
    stale_rdy = 1'b0;
  endtask

  task automatic test_flush();
    bit bad = 1'b0;
    ex_is_mult = 1'b1; ex_is_div = 1'b0; ex_opA = 32'd3; ex_opB = 32'd4; ex_rd = 5'd7;
    wait_ctrl("flush");
    repeat (5) @(posedge clock);
    #1;
    flush = 1'b1; ex_is_mult = 1'b0;
    @(negedge clock);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL flush pre_flush_busy: got %b want 1", busy);
    end
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    n_vec++;
    if ({busy, stall, wb_valid} !== 3'b000) begin
      n_err++; $display("FAIL flush idle: got busy=%b stall=%b wb_valid=%b want 0 0 0", busy, stall, wb_valid);
    end
    n_vec++;
    if (md_operandA !== 32'd3 || md_operandB !== 32'd4) begin
      n_err++; $display("FAIL flush operands_kept: got %h %h want 3 4", md_operandA, md_operandB);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (wb_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL flush quiet: got activity after flush want none");
    end
    @(posedge clock); #1;
    run_op("mult_r0", 1'b1, 1'b0, 32'd5, 32'd5, 5'd0, 1'b0, 5'd0, 32'd0, 17);
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    ex_is_mult = 1'b1; ex_is_div = 1'b0; ex_opA = 32'd2; ex_opB = 32'd3; ex_rd = 5'd1;
    wait_ctrl("reset_mid");
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1; ex_is_mult = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("reset_mid");
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (wb_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL reset_mid quiet: got activity after reset want none");
    end
    @(posedge clock); #1;
  endtask

`ifdef MULTDIV_TIMEOUT_EN
  task automatic test_timeout();
    model_lat = 0;
    run_op("timeout_div", 1'b0, 1'b1, 32'd9, 32'd3, 5'd8, 1'b1, 5'd30, 32'd5, 41);
    model_lat = 16;
  endtask
`endif

  initial begin
    reset = 1'b1; flush = 1'b0;
    ex_is_mult = 1'b0; ex_is_div = 1'b0; ex_rd = '0; ex_opA = '0; ex_opB = '0;
    test_reset();
    test_mult();
    test_div();
    test_mult_overflow();
    test_mult_wins();
    test_stale_rdy();
    test_flush();
    test_reset_mid();
`ifdef MULTDIV_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
